// File: rtl/zx_video_pkg.sv
// Shared constants and types for the ZX80/ZX81 scandoubler video path.
package zx_video_pkg;

    localparam int unsigned LINE_LEN   = 414;
    localparam int unsigned HS_END     = 384;
    localparam int unsigned VS_THRESH  = 90;
    localparam int unsigned LOCK_LINES = 4;
    localparam int unsigned MAX_LINES  = 320;
    localparam int unsigned LOCK_TOL   = 8;

    localparam int unsigned COL_W    = 10;
    localparam int unsigned RD_COL_W = 9;
    localparam int unsigned LINE_W   = 10;
    localparam int unsigned LEN_W    = 8;
    localparam int unsigned SPC_W    = 12;

    typedef enum logic [1:0] {
        ST_SEARCH,
        ST_COUNT,
        ST_LOCKED
    } lock_state_e;

endpackage

// File: rtl/csync_filter.sv
// Composite-sync conditioning: synchronizer, 2-tick glitch filter,
// sync-length measurement and hsync-end / vsync event generation.
module csync_filter
    import zx_video_pkg::*;
#(
    parameter int unsigned VS_LEN_TICKS = zx_video_pkg::VS_THRESH
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic ce_i,
    input  logic csync_i,
    output logic filt_o,
    output logic hs_evt_o,
    output logic vs_evt_o
);

    localparam logic [LEN_W-1:0] VS_LEN = LEN_W'(VS_LEN_TICKS);

    logic             sync1_q, sync2_q;
    logic             smp_q, filt_q;
    logic [LEN_W-1:0] len_q, len_d;
    logic             rise;

    always_comb begin
        len_d = len_q;
        if (filt_q)
            len_d = '0;
        else if (len_q != '1)
            len_d = len_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            smp_q   <= 1'b1;
            filt_q  <= 1'b1;
            len_q   <= '0;
        end else begin
            sync1_q <= csync_i;
            sync2_q <= sync1_q;
            if (ce_i) begin
                smp_q <= sync2_q;
                if (sync2_q == smp_q)
                    filt_q <= sync2_q;
                len_q <= len_d;
            end
        end
    end

    // Rising edge is the tick on which the filtered value flips low->high;
    // len_q still holds the length of the pulse that is ending.
    assign rise     = ce_i && !filt_q && sync2_q && smp_q;
    assign hs_evt_o = rise && (len_q < VS_LEN);
    assign vs_evt_o = ce_i && !filt_q && (len_q == VS_LEN);
    assign filt_o   = filt_q;

endmodule

// File: rtl/csync_line_sequencer.sv
// Scandoubler line-buffer sequencer: ping-pong addressing, doubled-rate
// hsync/vsync, line counting and sync lock detection from raw csync.
module csync_line_sequencer #(
    parameter int unsigned LINE_LEN   = zx_video_pkg::LINE_LEN,
    parameter int unsigned HS_END     = zx_video_pkg::HS_END,
    parameter int unsigned VS_THRESH  = zx_video_pkg::VS_THRESH,
    parameter int unsigned LOCK_LINES = zx_video_pkg::LOCK_LINES,
    parameter int unsigned MAX_LINES  = zx_video_pkg::MAX_LINES
) (
    input  logic       clkvga,
    input  logic       rst_n,
    input  logic       ce_2pix,
    input  logic       csync,
    output logic [9:0] wr_addr,
    output logic       wr_en,
    output logic [9:0] rd_addr,
    output logic       hs_out,
    output logic       vs_out,
    output logic [9:0] line_cnt,
    output logic       line_start,
    output logic       frame_start,
    output logic       locked
);

    import zx_video_pkg::*;

    localparam int unsigned GOOD_W = $clog2(LOCK_LINES + 1);

    localparam logic [RD_COL_W-1:0] LAST_COL   = RD_COL_W'(LINE_LEN - 1);
    localparam logic [RD_COL_W-1:0] HS_END_C   = RD_COL_W'(HS_END);
    localparam logic [LINE_W-1:0]   LAST_LINE  = LINE_W'(MAX_LINES - 1);
    localparam logic [SPC_W-1:0]    SPC_LO     = SPC_W'(2 * LINE_LEN - LOCK_TOL);
    localparam logic [SPC_W-1:0]    SPC_HI     = SPC_W'(2 * LINE_LEN + LOCK_TOL);
    localparam logic [SPC_W-1:0]    TIMEOUT_M1 = SPC_W'(4 * LINE_LEN - 1);
    localparam logic [GOOD_W-1:0]   LOCK_C     = GOOD_W'(LOCK_LINES);

    logic filt, hs_evt, vs_evt;

    csync_filter #(
        .VS_LEN_TICKS(VS_THRESH)
    ) u_filter (
        .clk_i   (clkvga),
        .rst_ni  (rst_n),
        .ce_i    (ce_2pix),
        .csync_i (csync),
        .filt_o  (filt),
        .hs_evt_o(hs_evt),
        .vs_evt_o(vs_evt)
    );

    logic [COL_W-1:0]    zx_col_q, zx_col_d;
    logic [RD_COL_W-1:0] rd_col_q, rd_col_d;
    logic [LINE_W-1:0]   line_cnt_q, line_cnt_d;
    logic                bank_q, bank_d;
    logic                hs_q, hs_d;
    logic                vs_q, vs_d;
    logic                ls_q, ls_d;
    logic                fs_q, fs_d;
    logic                rd_wrap;

    assign rd_wrap = (rd_col_q == LAST_COL);

    // An hsync-end landing on the wrap tick folds into one reset and one pulse.
    always_comb begin
        zx_col_d   = zx_col_q;
        rd_col_d   = rd_col_q;
        line_cnt_d = line_cnt_q;
        bank_d     = bank_q;
        hs_d       = hs_q;
        vs_d       = vs_q;
        ls_d       = ce_2pix && (hs_evt || rd_wrap);
        fs_d       = vs_evt;
        if (ce_2pix) begin
            rd_col_d = (hs_evt || rd_wrap) ? '0 : rd_col_q + 1'b1;
            zx_col_d = hs_evt ? '0 : zx_col_q + 1'b1;
            bank_d   = hs_evt ? !bank_q : bank_q;
            hs_d     = (rd_col_q < HS_END_C);
            if (vs_evt)
                vs_d = 1'b1;
            else if (filt)
                vs_d = 1'b0;
            if (vs_evt)
                line_cnt_d = '0;
            else if (hs_evt && (line_cnt_q != LAST_LINE))
                line_cnt_d = line_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clkvga or negedge rst_n) begin
        if (!rst_n) begin
            zx_col_q   <= '0;
            rd_col_q   <= '0;
            line_cnt_q <= '0;
            bank_q     <= 1'b0;
            hs_q       <= 1'b0;
            vs_q       <= 1'b0;
            ls_q       <= 1'b0;
            fs_q       <= 1'b0;
        end else begin
            zx_col_q   <= zx_col_d;
            rd_col_q   <= rd_col_d;
            line_cnt_q <= line_cnt_d;
            bank_q     <= bank_d;
            hs_q       <= hs_d;
            vs_q       <= vs_d;
            ls_q       <= ls_d;
            fs_q       <= fs_d;
        end
    end

    lock_state_e       state_q;
    logic [GOOD_W-1:0] good_q, good_inc;
    logic [SPC_W-1:0]  spc_q, idle_q, spacing;
    logic              locked_q, in_win, timeout;

    // spc_q counts ticks since the previous hsync-end, so the spacing is one more.
    assign spacing  = spc_q + 1'b1;
    assign in_win   = (spacing >= SPC_LO) && (spacing <= SPC_HI);
    assign good_inc = good_q + 1'b1;
    assign timeout  = !hs_evt && !vs_evt && (idle_q >= TIMEOUT_M1);

    always_ff @(posedge clkvga or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_SEARCH;
            good_q   <= '0;
            spc_q    <= '0;
            idle_q   <= '0;
            locked_q <= 1'b0;
        end else if (ce_2pix) begin
            spc_q  <= hs_evt ? '0 : ((spc_q == '1) ? spc_q : spc_q + 1'b1);
            idle_q <= (hs_evt || vs_evt) ? '0 : ((idle_q == '1) ? idle_q : idle_q + 1'b1);
            case (state_q)
                ST_SEARCH: begin
                    if (hs_evt) begin
                        state_q <= ST_COUNT;
                        good_q  <= '0;
                    end
                end
                ST_COUNT: begin
                    if (hs_evt) begin
                        if (in_win) begin
                            good_q <= good_inc;
                            if (good_inc == LOCK_C) begin
                                state_q  <= ST_LOCKED;
                                locked_q <= 1'b1;
                            end
                        end else begin
                            good_q <= '0;
                        end
                    end
                end
                ST_LOCKED: begin
                    if ((hs_evt && !in_win) || timeout) begin
                        state_q  <= ST_SEARCH;
                        locked_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= ST_SEARCH;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

    assign wr_addr     = {bank_q, zx_col_q[COL_W-1:1]};
    assign wr_en       = ce_2pix && zx_col_q[0];
    assign rd_addr     = {!bank_q, rd_col_q};
    assign hs_out      = hs_q;
    assign vs_out      = vs_q;
    assign line_cnt    = line_cnt_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;
    assign locked      = locked_q;

endmodule

// File: doc/csync_line_sequencer.md
# csync_line_sequencer

Sequencing controller for the scandoubler line-buffer datapath in the ZX80/ZX81 video path. It recovers line and frame timing from the raw active-low composite sync. It generates the ping-pong write/read addresses and bank selects for the 1024x1 line buffer, and drives the doubled-rate hsync/vsync, line counter and lock status consumed by the VGA output and OSD. Pixel storage, the buffer RAM and the scanline/blanking mix stay outside this block.

## Interface
- `LINE_LEN`, 414: output columns per doubled line (counter wraps at LINE_LEN-1).
- `HS_END`, 384: hs_out high while rd column < HS_END.
- `VS_THRESH`, 90: sync-low length (ce ticks) that marks vsync.
- `LOCK_LINES`, 4: consecutive good lines needed to lock.
- `MAX_LINES`, 320: line_cnt ceiling without vsync.

- `clkvga`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `ce_2pix`  in  1  clock enable. All state advances only when high.
- `csync`  in  1  raw composite sync, low = sync, asynchronous.
- `wr_addr`  out  10  line-buffer write address {wbank, zx_col[9:1]}.
- `wr_en`  out  1  write strobe, high when ce_2pix and zx_col[0].
- `rd_addr`  out  10  line-buffer read address {rbank, rd_col}.
- `hs_out`  out  1  doubled-rate hsync.
- `vs_out`  out  1  vsync, high from vsync detection until csync goes high.
- `line_cnt`  out  10  doubled-line index since last vsync.
- `line_start`  out  1  one-clock pulse when rd_col returns to 0.
- `frame_start`  out  1  one-clock pulse at vsync detection.
- `locked`  out  1  high in state LOCKED.

## Operation
- csync passes through a 2-flop synchronizer on clkvga, then a 2-tick glitch filter on ce_2pix. The filtered value changes only after 2 equal consecutive samples.
- sync_len (8 bit) clears while filtered csync is high. It increments while low and saturates at 255.
- vsync event: sync_len == VS_THRESH. Effects: set vs_out, clear line_cnt, pulse frame_start.
- hsync-end event: rising edge of filtered csync with sync_len < VS_THRESH. Effects:
  - clear zx_col and rd_col;
  - toggle bank, so rbank <= old bank and wbank <= !old bank;
  - increment line_cnt.
- A rising edge after a vsync-length pulse clears sync_len only. It causes no column reset and no bank toggle.
- rd_col increments each tick and wraps at LINE_LEN-1. Each wrap and each hsync-end pulses line_start for one clock. Both produce a doubled line per zx line.
- zx_col (10 bit) increments each tick and wraps naturally at 1023.
- line_cnt saturates at MAX_LINES-1.
- FSM states:
  - SEARCH: after reset. Go to COUNT on the first hsync-end.
  - COUNT: measures the ticks between hsync-ends. If a spacing is within 2*LINE_LEN ±8, increment good. Any other spacing clears good. Go to LOCKED when good == LOCK_LINES.
  - LOCKED: go to SEARCH when no hsync-end and no vsync occurs for 4*LINE_LEN ticks, or on a spacing error outside ±8.
  - All state transitions of the lock FSM are qualified by ce_2pix.
- Addresses, hs and bank logic run identically in every state. Only `locked` reflects the FSM.

## Timing
- Reset values (async): wr_addr 0, rd_addr 0x200 (rbank 1), wbank 0, hs_out 0, vs_out 0, line_cnt 0, line_start 0, frame_start 0, locked 0, FSM SEARCH, counters 0.
- csync to internal edge: 2 clkvga plus 2 ce ticks.
- hs_out is registered, so it lags rd_col by one ce tick.
- Priority: vsync event over hsync-end. An hsync-end on the same tick as the rd_col wrap is a single reset, with exactly one line_start.
- If vsync detection and a line_cnt increment coincide, line_cnt becomes 0.
- Reset mid-line: all outputs take their reset values immediately. The first hsync-end after reset re-aligns the columns.

## Structure
- Shared package `zx_video_pkg` holds the constants LINE_LEN, HS_END, VS_THRESH, the column and line widths, and the FSM state enum.
- One sub-module, `csync_filter`, contains the synchronizer, glitch filter, sync_len counter and edge/vsync event outputs.
- The top level holds the column counters, bank toggle, line counter and lock FSM.

## Test plan
- Reset with csync high: all outputs at their reset values. After release with no sync, rd_col free-runs and line_start pulses every 414 ticks.
- 5 lines of 20-tick sync low in an 828-tick period:
  - bank toggles each line;
  - wr_addr[9] is opposite rd_addr[9];
  - locked rises after the 4th good spacing.
- A 100-tick low pulse:
  - vs_out rises at tick 90 of low;
  - line_cnt becomes 0 and frame_start pulses once;
  - the rising edge causes no bank toggle.
- A 1-tick csync glitch mid-line: no event and no column reset.
- A spacing of 900 ticks while LOCKED: state goes to SEARCH and locked drops.
- rst_n asserted mid-line during LOCKED: async clear on the same edge, with rd_addr at 0x200.
